// File: rtl/exc_ctrl_pkg.sv
// Shared cop0 operation codes, MIPS ExcCode values and sequencer state for exc_ctrl.
// The optional interval timer is enabled with the COP_TIMER_EN macro.
package exc_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 20;
  localparam int unsigned CAUSE_W = 5;

  typedef enum logic [2:0] {
    COP_OP_NOP = 3'd0,
    COP_OP_MV  = 3'd1,
    COP_OP_EN  = 3'd2,
    COP_OP_DIS = 3'd3,
    COP_OP_RET = 3'd4,
    COP_OP_SYS = 3'd5,
    COP_OP_BRK = 3'd6,
    COP_OP_EXC = 3'd7
  } cop_op_e;

  localparam logic [CAUSE_W-1:0] EXC_INT = 5'd0;
  localparam logic [CAUSE_W-1:0] EXC_SYS = 5'd8;
  localparam logic [CAUSE_W-1:0] EXC_BP  = 5'd9;
  localparam logic [CAUSE_W-1:0] EXC_RI  = 5'd10;
  localparam logic [CAUSE_W-1:0] EXC_OV  = 5'd11 + 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } exc_state_e;

  // Return address for a faulting instruction that is considered executed.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/exc_ctrl_timer.sv
// cop_timer: free-running COUNT, software-loaded COMPARE and the sticky timer-pending bit.
// Only instantiated when COP_TIMER_EN is defined.
module cop_timer
  import exc_ctrl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmp_wr,
  input  logic [XLEN-1:0] i_cmp_data,
  output logic            o_pending,
  output logic [XLEN-1:0] o_count
);

  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] r_compare;
  logic            r_pending;
  logic            w_match;

  assign w_match = (r_count == r_compare) && (r_compare != '0);

  // A COMPARE write acknowledges the timer and beats a match in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= r_count + XLEN'(1);
      if (i_cmp_wr) begin
        r_compare <= i_cmp_data;
        r_pending <= 1'b0;
      end else if (w_match) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_count   = r_count;

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: picks one exception/eret/interrupt per event, issues a single cop0 op, then flushes and redirects fetch.
// Define COP_TIMER_EN to OR the cop_timer pending bit into the top interrupt line.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ex_valid,
  input  logic [XLEN-1:0]      i_ex_pc,
  input  logic                 i_ex_syscall,
  input  logic                 i_ex_break,
  input  logic                 i_ex_ri,
  input  logic                 i_ex_ovf,
  input  logic                 i_ex_eret,
  input  logic [CODE_W-1:0]    i_ex_code,
  input  logic [IRQ_W-1:0]     i_irq,
  input  logic                 i_status_ie,
  input  logic                 i_status_exl,
  input  logic                 i_cmp_wr,
  input  logic [XLEN-1:0]      i_cmp_data,
  input  logic [XLEN-1:0]      i_cop_rdata,
  output logic [2:0]           o_cop_op,
  output logic [CODE_W-1:0]    o_cop_code,
  output logic [XLEN-1:0]      o_cop_next_pc,
  output logic [CAUSE_W-1:0]   o_exc_cause,
  output logic                 o_stall,
  output logic                 o_pipe_flush,
  output logic                 o_pc_redirect,
  output logic [XLEN-1:0]      o_redirect_pc
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  exc_state_e          r_state;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic [IRQ_W-1:0]    r_irq_q;
  cop_op_e             r_cop_op;
  logic [CODE_W-1:0]   r_cop_code;
  logic [XLEN-1:0]     r_cop_next_pc;
  logic [CAUSE_W-1:0]  r_exc_cause;
  logic                r_stall;
  logic                r_pipe_flush;
  logic                r_pc_redirect;
  logic [XLEN-1:0]     r_redirect_pc;

  logic [IRQ_W-1:0]    w_irq_in;
  logic                w_int_req;
  logic                w_evt;
  logic                w_is_eret;
  cop_op_e             w_op;
  logic [CODE_W-1:0]   w_code;
  logic [XLEN-1:0]     w_npc;
  logic [CAUSE_W-1:0]  w_cause;

`ifdef COP_TIMER_EN
  logic                w_timer_pend;
  logic [XLEN-1:0]     w_timer_count;

  cop_timer u_cop_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cmp_wr   (i_cmp_wr),
    .i_cmp_data (i_cmp_data),
    .o_pending  (w_timer_pend),
    .o_count    (w_timer_count)
  );

  logic w_unused_count;
  assign w_unused_count = ^w_timer_count;
  assign w_irq_in = i_irq | {w_timer_pend, {(IRQ_W-1){1'b0}}};
`else
  logic w_unused_cmp;
  assign w_unused_cmp = i_cmp_wr ^ (^i_cmp_data);
  assign w_irq_in = i_irq;
`endif

  assign w_int_req = (|r_irq_q) & i_status_ie & ~i_status_exl;

  // Fixed-priority event select; an interrupt pre-empts the EX instruction, so EPC is its own PC.
  always_comb begin
    w_evt     = 1'b1;
    w_is_eret = 1'b0;
    w_op      = COP_OP_NOP;
    w_code    = '0;
    w_npc     = '0;
    w_cause   = EXC_INT;
    if (w_int_req) begin
      w_op  = COP_OP_EXC;
      w_npc = i_ex_pc;
    end else if (i_ex_valid && i_ex_ri) begin
      w_op    = COP_OP_EXC;
      w_npc   = next_pc(i_ex_pc);
      w_cause = EXC_RI;
    end else if (i_ex_valid && i_ex_syscall) begin
      w_op    = COP_OP_SYS;
      w_code  = i_ex_code;
      w_npc   = next_pc(i_ex_pc);
      w_cause = EXC_SYS;
    end else if (i_ex_valid && i_ex_break) begin
      w_op    = COP_OP_BRK;
      w_code  = i_ex_code;
      w_npc   = next_pc(i_ex_pc);
      w_cause = EXC_BP;
    end else if (i_ex_valid && i_ex_ovf) begin
      w_op    = COP_OP_EXC;
      w_npc   = next_pc(i_ex_pc);
      w_cause = EXC_OV;
    end else if (i_ex_valid && i_ex_eret) begin
      w_op      = COP_OP_RET;
      w_is_eret = 1'b1;
    end else begin
      w_evt = 1'b0;
    end
  end

  // Sequencer: IDLE -> CAPTURE -> FLUSH (FLUSH_CYCLES) -> REDIRECT -> IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_flush_cnt   <= '0;
      r_irq_q       <= '0;
      r_cop_op      <= COP_OP_NOP;
      r_cop_code    <= '0;
      r_cop_next_pc <= '0;
      r_exc_cause   <= '0;
      r_stall       <= 1'b0;
      r_pipe_flush  <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_irq_q <= w_irq_in;
      case (r_state)
        ST_IDLE: begin
          if (w_evt) begin
            r_state       <= ST_CAPTURE;
            r_cop_op      <= w_op;
            r_cop_code    <= w_code;
            r_cop_next_pc <= w_npc;
            if (!w_is_eret) r_exc_cause <= w_cause;
            r_stall       <= 1'b1;
            r_pipe_flush  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          // cop0 answers combinationally while the op is on the bus.
          r_redirect_pc <= i_cop_rdata;
          r_cop_op      <= COP_OP_NOP;
          r_flush_cnt   <= CNT_W'(FLUSH_CYCLES);
          r_state       <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == CNT_W'(1)) begin
            r_state       <= ST_REDIRECT;
            r_stall       <= 1'b0;
            r_pipe_flush  <= 1'b0;
            r_pc_redirect <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - CNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          r_pc_redirect <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cop_op      = r_cop_op;
  assign o_cop_code    = r_cop_code;
  assign o_cop_next_pc = r_cop_next_pc;
  assign o_exc_cause   = r_exc_cause;
  assign o_stall       = r_stall;
  assign o_pipe_flush  = r_pipe_flush;
  assign o_pc_redirect = r_pc_redirect;
  assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected cop0 ops and redirects, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_syscall = 1'b0, ex_break = 1'b0, ex_ri = 1'b0, ex_ovf = 1'b0, ex_eret = 1'b0;
  logic [19:0] ex_code = '0;
  logic [5:0]  irq = '0;
  logic        status_ie = 1'b1, status_exl = 1'b0;
  logic        cmp_wr = 1'b0;
  logic [31:0] cmp_data = '0;
  logic [31:0] cop_rdata = '0;
  logic [2:0]  cop_op;
  logic [19:0] cop_code;
  logic [31:0] cop_next_pc;
  logic [4:0]  exc_cause;
  logic        stall, pipe_flush, pc_redirect;
  logic [31:0] redirect_pc;

  exc_ctrl #(.IRQ_W(6), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_pc(ex_pc),
    .i_ex_syscall(ex_syscall), .i_ex_break(ex_break), .i_ex_ri(ex_ri), .i_ex_ovf(ex_ovf),
    .i_ex_eret(ex_eret), .i_ex_code(ex_code), .i_irq(irq), .i_status_ie(status_ie),
    .i_status_exl(status_exl), .i_cmp_wr(cmp_wr), .i_cmp_data(cmp_data), .i_cop_rdata(cop_rdata),
    .o_cop_op(cop_op), .o_cop_code(cop_code), .o_cop_next_pc(cop_next_pc), .o_exc_cause(exc_cause),
    .o_stall(stall), .o_pipe_flush(pipe_flush), .o_pc_redirect(pc_redirect), .o_redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [19:0] code;
    logic [31:0] npc;
    logic [4:0]  cause;
  } op_exp_t;

  op_exp_t     op_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_ops = 0;
  int          lat = 0;
  int          fl_cnt = 0;
  bit          in_evt = 1'b0;
  op_exp_t     e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input cop_op_e op, input logic [19:0] code, input logic [31:0] npc,
                      input logic [4:0] cause, input logic [31:0] rpc, input bit has_rd);
    op_exp_t x;
    x.op = op; x.code = code; x.npc = npc; x.cause = cause;
    op_q.push_back(x);
    if (has_rd) rd_q.push_back(rpc);
  endtask

  // Monitor: compares every issued op and redirect against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      in_evt = 1'b0;
    end else begin
      if (in_evt) begin
        lat++;
        if (pipe_flush) fl_cnt++;
      end
      if (cop_op != 3'(COP_OP_NOP)) begin
        n_ops++;
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_op: got op %0d expected none at %0t", cop_op, $time);
        end else begin
          e = op_q.pop_front();
          chk("cop_op", 32'(cop_op), 32'(e.op));
          chk("cop_code", 32'(cop_code), 32'(e.code));
          chk("cop_next_pc", cop_next_pc, e.npc);
          chk("exc_cause", 32'(exc_cause), 32'(e.cause));
          chk("stall_in_capture", 32'(stall), 32'd1);
        end
        in_evt = 1'b1;
        lat    = 0;
        fl_cnt = pipe_flush ? 1 : 0;
      end
      if (pc_redirect) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect: got pc 0x%08h expected none at %0t", redirect_pc, $time);
        end else begin
          chk("redirect_pc", redirect_pc, rd_q.pop_front());
          chk("redirect_latency", 32'(lat), 32'(FC + 1));
          chk("flush_cycles", 32'(fl_cnt), 32'(FC + 1));
        end
        in_evt = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_syscall = 0; ex_break = 0; ex_ri = 0; ex_ovf = 0; ex_eret = 0;
  endtask

  // Presents EX flags {ri,sys,brk,ovf,eret} for 'hold' clock edges.
  task automatic send(input logic [31:0] pc, input logic [4:0] f, input logic [19:0] code,
                      input logic vld, input logic [31:0] rdata, input int hold);
    ex_pc = pc; ex_code = code; ex_valid = vld; cop_rdata = rdata;
    {ex_ri, ex_syscall, ex_break, ex_ovf, ex_eret} = f;
    idle(hold);
    clr_ex();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cop_op"}, 32'(cop_op), 32'(COP_OP_NOP));
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_flush"}, 32'(pipe_flush), 32'd0);
    chk({tag, "_redirect"}, 32'(pc_redirect), 32'd0);
  endtask

  initial begin
    idle(3);
    chk_quiet("reset");
    chk("reset_cop_code", 32'(cop_code), 32'd0);
    chk("reset_next_pc", cop_next_pc, 32'd0);
    chk("reset_cause", 32'(exc_cause), 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    idle(2);

    // syscall, then eret (cause must stay Sys)
    push(COP_OP_SYS, 20'h12, 32'h104, 5'd8, 32'h3000, 1);
    send(32'h100, 5'b01000, 20'h12, 1, 32'h3000, 1);
    idle(6);
    push(COP_OP_RET, 20'h0, 32'h0, 5'd8, 32'h480, 1);
    send(32'h700, 5'b00001, 20'h55, 1, 32'h480, 1);
    idle(6);

    // interrupt beats overflow; EPC is the un-committed PC
    irq = 6'b000001;
    idle(1);
    push(COP_OP_EXC, 20'h0, 32'h200, 5'd0, 32'h9000, 1);
    send(32'h200, 5'b00010, 20'h33, 1, 32'h9000, 1);
    irq = '0;
    idle(6);

    // RI beats syscall; break at top of address space wraps EPC
    push(COP_OP_EXC, 20'h0, 32'h304, 5'd10, 32'h1111, 1);
    send(32'h300, 5'b11000, 20'h7, 1, 32'h1111, 1);
    idle(6);
    push(COP_OP_BRK, 20'hABCDE, 32'h0, 5'd9, 32'h2222, 1);
    send(32'hFFFF_FFFC, 5'b00100, 20'hABCDE, 1, 32'h2222, 1);
    idle(6);
    push(COP_OP_EXC, 20'h0, 32'h404, 5'd12, 32'h3333, 1);
    send(32'h400, 5'b00010, 20'h5, 1, 32'h3333, 1);
    idle(6);
    push(COP_OP_BRK, 20'h1, 32'h504, 5'd9, 32'h3344, 1);
    send(32'h500, 5'b00110, 20'h1, 1, 32'h3344, 1);
    idle(6);

    // invalid EX instruction and masked interrupts are ignored
    send(32'h900, 5'b01000, 20'h2, 0, 32'h0, 2);
    status_ie = 1'b0; irq = 6'b000001;
    idle(20);
    irq = '0; idle(3);
    status_ie = 1'b1; status_exl = 1'b1; irq = 6'b100000;
    idle(20);
    chk_quiet("masked");
    irq = '0; idle(3);
    status_exl = 1'b0;
    idle(2);

    // held syscall: accepted again only after the REDIRECT cycle
    push(COP_OP_SYS, 20'h21, 32'hA04, 5'd8, 32'h6000, 1);
    push(COP_OP_SYS, 20'h21, 32'hA04, 5'd8, 32'h6000, 1);
    send(32'hA00, 5'b01000, 20'h21, 1, 32'h6000, 6);
    idle(8);

    // reset in the second FLUSH cycle aborts the redirect
    push(COP_OP_SYS, 20'h44, 32'h604, 5'd8, 32'h0, 0);
    send(32'h600, 5'b01000, 20'h44, 1, 32'h7777, 1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_quiet("midrst");
    chk("midrst_cause", 32'(exc_cause), 32'd0);
    idle(1);
    push(COP_OP_SYS, 20'h9, 32'h804, 5'd8, 32'h4444, 1);
    send(32'h800, 5'b01000, 20'h9, 1, 32'h4444, 1);
    idle(8);

`ifdef COP_TIMER_EN
    begin
      int prev;
      bit seen;
      rst = 1'b1; idle(2); rst = 1'b0;
      ex_pc = 32'h500;
      cmp_wr = 1'b1; cmp_data = 32'd10;
      idle(1);
      cmp_wr = 1'b0;
      push(COP_OP_EXC, 20'h0, 32'h500, 5'd0, 32'h5555, 1);
      cop_rdata = 32'h5555;
      prev = n_ops; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        idle(1);
        if (n_ops > prev) seen = 1;
      end
      chk("timer_irq_seen", 32'(seen), 32'd1);
      cmp_wr = 1'b1; cmp_data = 32'd0;
      idle(1);
      cmp_wr = 1'b0;
      idle(10);

      rst = 1'b1; idle(2); rst = 1'b0;
      cmp_wr = 1'b1; cmp_data = 32'd5;
      idle(1);
      cmp_wr = 1'b0;
      idle(4);
      cmp_wr = 1'b1; cmp_data = 32'd5;
      idle(1);
      cmp_wr = 1'b0;
      idle(20);
      chk_quiet("timer_ack");
      cmp_wr = 1'b1; cmp_data = 32'd0;
      idle(1);
      cmp_wr = 1'b0;
      idle(4);
    end
`endif

    idle(4);
    chk("op_queue_drained", 32'(op_q.size()), 32'd0);
    chk("redirect_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
